// File: rtl/switch_debouncer_if.sv
// Switch-conditioning bundle: raw switch levels in, debounced levels, edge pulses,
// sampling tick and transition count out.
interface switch_debouncer_if #(
    parameter int unsigned NUM_SW = 18
);
    logic [NUM_SW-1:0] SWITCH_I;
    logic [NUM_SW-1:0] SWITCH_DB_O;
    logic [NUM_SW-1:0] SWITCH_RISE_O;
    logic [NUM_SW-1:0] SWITCH_FALL_O;
    logic              TICK_O;
    logic [7:0]        CHANGE_COUNT_O;

    // Board/consumer side: drives raw switches, reads conditioned results.
    modport master (
        output SWITCH_I,
        input  SWITCH_DB_O,
        input  SWITCH_RISE_O,
        input  SWITCH_FALL_O,
        input  TICK_O,
        input  CHANGE_COUNT_O
    );

    // Debouncer side.
    modport slave (
        input  SWITCH_I,
        output SWITCH_DB_O,
        output SWITCH_RISE_O,
        output SWITCH_FALL_O,
        output TICK_O,
        output CHANGE_COUNT_O
    );
endinterface

// File: rtl/switch_debouncer.sv
// Synchronises and debounces NUM_SW raw switches on a shared sampling tick, producing
// clean levels, one-cycle rise/fall pulses and a modulo-256 transition count.
module switch_debouncer #(
    parameter int unsigned NUM_SW       = 18,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic               CLOCK_50_I,
    input  logic               RESET_I,
    switch_debouncer_if.slave  sw
);
    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STABLE_TICKS - 1);

    logic [NUM_SW-1:0]  sync1_q;
    logic [NUM_SW-1:0]  sync2_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_nxt;
    logic               tick;
    logic               tick_q;
    logic               tick_nxt;
    logic [CNT_W-1:0]   cnt_q   [NUM_SW];
    logic [CNT_W-1:0]   cnt_nxt [NUM_SW];
    logic [NUM_SW-1:0]  db_q;
    logic [NUM_SW-1:0]  db_nxt;
    logic [NUM_SW-1:0]  rise_q;
    logic [NUM_SW-1:0]  fall_q;
    logic [7:0]         count_q;
    logic [7:0]         edge_pop;

    assign tick = (presc_q == TICK_LAST);

    // Prescaler and per-bit stability counters; db only moves on tick cycles.
    always_comb begin
        presc_nxt = tick ? '0 : presc_q + PRESC_W'(1);
        tick_nxt  = (presc_nxt == TICK_LAST);
        db_nxt    = db_q;
        cnt_nxt   = cnt_q;
        if (tick) begin
            for (int i = 0; i < int'(NUM_SW); i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_nxt[i]  = sync2_q[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Number of bits that produced a pulse in the current cycle.
    always_comb begin
        edge_pop = '0;
        for (int i = 0; i < int'(NUM_SW); i++) begin
            edge_pop = edge_pop + 8'(rise_q[i] | fall_q[i]);
        end
    end

    // Pulses are computed from the next db so they line up with the new level.
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '{default: '0};
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            count_q <= '0;
        end else begin
            sync1_q <= sw.SWITCH_I;
            sync2_q <= sync1_q;
            presc_q <= presc_nxt;
            tick_q  <= tick_nxt;
            cnt_q   <= cnt_nxt;
            db_q    <= db_nxt;
            rise_q  <= db_nxt & ~db_q;
            fall_q  <= ~db_nxt & db_q;
            count_q <= count_q + edge_pop;
        end
    end

    assign sw.SWITCH_DB_O    = db_q;
    assign sw.SWITCH_RISE_O  = rise_q;
    assign sw.SWITCH_FALL_O  = fall_q;
    assign sw.TICK_O         = tick_q;
    assign sw.CHANGE_COUNT_O = count_q;
endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the 18 DE2 toggle switches before any logic consumes them. Each raw switch is synchronised to the 50 MHz clock and debounced on a shared sampling tick. The block delivers a clean level vector, single-cycle rise/fall event pulses and a running toggle count. It sits between the board switch pins and the boolean/LED logic, which reads switch state instead of driving it from switches directly.

## Interface
- NUM_SW, default 18: number of switch inputs.
- TICK_DIV, default 50000: clock cycles per sampling tick (1 ms at 50 MHz). Must be at least 1; a value of 1 means a tick every cycle.
- STABLE_TICKS, default 4: number of consecutive disagreeing ticks required to accept a new level. Must be at least 1.

Ports:
- CLOCK_50_I, input, 1: system clock, 50 MHz.
- RESET_I, input, 1: reset. One clock; reset is synchronous and active-high.
- SWITCH_I, input, NUM_SW: raw asynchronous switch levels.
- SWITCH_DB_O, output, NUM_SW: debounced levels (registered).
- SWITCH_RISE_O, output, NUM_SW: high for one cycle when the matching SWITCH_DB_O bit goes 0→1.
- SWITCH_FALL_O, output, NUM_SW: high for one cycle when the matching SWITCH_DB_O bit goes 1→0.
- TICK_O, output, 1: sampling tick, high for one cycle.
- CHANGE_COUNT_O, output, 8: total debounced transitions since reset, modulo 256.

## Operation
- Synchroniser: two flops per bit, sync1 then sync2; both reset to 0.
- Prescaler: counter runs 0..TICK_DIV-1.
  - TICK_O=1 when the counter is TICK_DIV-1; the counter then wraps to 0.
  - The counter is ceil(log2(TICK_DIV)) bits wide, minimum 1.
- Per-bit stability counter cnt[i], width ceil(log2(STABLE_TICKS+1)). It is updated only on tick cycles:
  - sync2[i] == db[i]: cnt[i] is cleared to 0.
  - sync2[i] != db[i] and cnt[i] < STABLE_TICKS-1: cnt[i] increments.
  - sync2[i] != db[i] and cnt[i] == STABLE_TICKS-1: db[i] takes sync2[i] and cnt[i] is cleared.
  - Net effect: a new level is accepted only after STABLE_TICKS consecutive disagreeing ticks. A single agreeing tick restarts the count.
- Non-tick cycles leave cnt and db unchanged. Glitches between ticks are invisible by design.
- Edge detect:
  - db_d is a registered copy of db.
  - SWITCH_RISE_O = db & ~db_d; SWITCH_FALL_O = ~db & db_d.
  - Each pulse is high in the first cycle the new SWITCH_DB_O value is visible.
- Counter: each cycle, CHANGE_COUNT_O adds popcount(SWITCH_RISE_O | SWITCH_FALL_O).
  - Several bits changing on the same tick add their full count in one cycle.
  - The 8-bit sum wraps 255→0 with no saturation.
- Bits are independent; no priority between switches.

## Timing
- Reset values: SWITCH_DB_O=0, SWITCH_RISE_O=0, SWITCH_FALL_O=0, TICK_O=0, CHANGE_COUNT_O=0. Prescaler, cnt, sync and db_d are all cleared.
- Reset mid-operation: all state is cleared on the next edge with RESET_I high, and the block relearns from zero.
  - Switches that are high at reset release produce normal rise pulses after the full latency.
  - Those rise pulses increment CHANGE_COUNT_O.
- Latency with TICK_DIV=1, for a clean step sampled at edge 1:
  - sync2 holds the new value after edge 2.
  - SWITCH_DB_O updates at edge 2+STABLE_TICKS.
  - The RISE/FALL pulse is high in the cycle that follows that edge.
- Latency with TICK_DIV>1: 2 cycles, plus up to TICK_DIV cycles of tick phase, plus (STABLE_TICKS-1)·TICK_DIV cycles.
- CHANGE_COUNT_O updates one edge after the pulse cycle.
- No input handshake. Outputs are always valid after reset.

## Test plan
- Reset with SWITCH_I=0x3FFFF, TICK_DIV=1, STABLE_TICKS=4, then release:
  - all outputs read 0 during reset;
  - SWITCH_DB_O=0x3FFFF exactly 6 edges after release, with SWITCH_RISE_O=0x3FFFF for one cycle;
  - CHANGE_COUNT_O=18 on the following edge.
- Clean step of bit 5 from 0 to 1, TICK_DIV=1, STABLE_TICKS=4:
  - SWITCH_DB_O[5] rises 6 edges after sampling;
  - one RISE pulse on bit 5 only;
  - CHANGE_COUNT_O increments by 1.
- Bounce on bit 0, TICK_DIV=1, STABLE_TICKS=4: toggle every 3 cycles for 30 cycles, then hold 1.
  - No pulses during the bounce.
  - A single rise occurs 6 cycles after the final hold begins.
- Wrap-around: drive 256 single-bit toggles, each held 10 cycles.
  - CHANGE_COUNT_O returns to 0, with no X values.
- Prescaler with TICK_DIV=5:
  - TICK_O is high every 5th cycle, starting on the 5th cycle after reset release.
  - With STABLE_TICKS=4, a step is accepted within 2+5+15 cycles.
- Reset mid-debounce: assert RESET_I while cnt is 2 and switch 3 is pending.
  - SWITCH_DB_O[3] stays 0 in the cycle after reset.
  - Relearning takes the full latency from release.
